ble_tx_sequencer: RTL and testbench
===================================

Name: ble_tx_sequencer

Overview:
Top-level controller for the BLE TX baseband chain (whitening/CRC → preamble insertion → modulator). It latches a transmit request, ramps the RF enable, pulses `restart` into the datapath, and monitors the final-stage AXI-Stream handshake to count emitted bits. It detects timeouts, length mismatches and aborts, then ramps down and reports completion status to the link-layer register block.

Parameters:
RampUpCycles, 40, aclk cycles from rf_tx_en rise to the restart pulse (PA settle).
RampDownCycles, 16, aclk cycles rf_tx_en stays high after the last bit handshake.
TimeoutCycles, 1024, maximum aclk cycles between consecutive monitored bit handshakes.
CntWidth, 12, bit counter width; must hold the maximum packet of 2128 bits.

Ports:
aclk  in  1  clock
areset  in  1  synchronous reset, active-high
start  in  1  single-cycle transmit request
abort  in  1  single-cycle abort request
phy  in  ble_phy_t  PHY selection, sampled on accepted start
pdu_len  in  8  PDU payload length in bytes, sampled on accepted start
restart  out  1  single-cycle pulse to the datapath stages
flush  out  1  high while the datapath is drained after an error or abort
rf_tx_en  out  1  RF front-end transmit enable
mon_tvalid  in  1  final-stage tvalid (monitor only)
mon_tready  in  1  final-stage tready (monitor only)
mon_tlast  in  1  final-stage tlast (monitor only)
busy  out  1  high in every state except IDLE
done  out  1  single-cycle pulse on return to IDLE
status  out  2  tx_status_t: OK=0, TIMEOUT=1, LEN_ERR=2, ABORTED=3; valid when done is high, held until the next start
bit_count  out  CntWidth  bits handshaken in the current or last packet

Behaviour:
- One clock; reset is synchronous and active-high. On reset all outputs are 0, status=OK, state=IDLE.
- Handshake event: hs = mon_tvalid & mon_tready. The block never drives the stream.
- Expected length latched at start:
  - PHY_1M: 8+32+(2+pdu_len)*8+24.
  - PHY_2M: 16+32+(2+pdu_len)*8+24.
  - PHY_CODED: no length check.
  - All arithmetic is CntWidth-wide and unsigned.
- State IDLE: start → latch phy and pdu_len, clear bit_count, set rf_tx_en=1, load the timer with RampUpCycles-1, go to RAMP_UP. abort is ignored in IDLE.
- State RAMP_UP: the timer decrements each cycle; at 0, restart=1 for exactly one cycle, the timer loads TimeoutCycles-1, go to ACTIVE.
- State ACTIVE:
  - On hs: bit_count increments and the timer reloads.
  - hs with mon_tlast: compare against the expected length. A mismatch (non-coded) sets status=LEN_ERR, otherwise status=OK. Go to RAMP_DOWN.
  - No hs and timer at 0: status=TIMEOUT, go to FLUSH.
- State FLUSH: flush=1 for exactly 1 cycle together with a restart pulse, then go to RAMP_DOWN.
- State RAMP_DOWN: the timer loads RampDownCycles-1 on entry; at 0, rf_tx_en=0, go to DONE.
- State DONE: done=1 for one cycle, go to IDLE.
- busy=1 in RAMP_UP, ACTIVE, FLUSH, RAMP_DOWN and DONE.
- abort in RAMP_UP or ACTIVE: status=ABORTED, go to FLUSH. abort in FLUSH, RAMP_DOWN or DONE is ignored.
- Simultaneous events:
  - abort together with a final hs+tlast in ACTIVE: abort wins; bit_count still increments.
  - start while busy: ignored; no queuing.
  - start in the same cycle as done: ignored. A new start is accepted from the first cycle in IDLE.
- bit_count saturates at all-ones and does not wrap. Saturation forces LEN_ERR for non-coded PHYs.
- areset mid-packet: immediate return to IDLE, rf_tx_en drops the next edge, and no done pulse is issued.
- Latency: start → restart is exactly RampUpCycles+1 cycles. Last hs → done is RampDownCycles+1 cycles.

Decomposition:
- tx_status_t and the preamble/access-address/CRC bit lengths (8, 16, 32, 24) go into the shared ble_types package next to ble_phy_t.
- The expected-length calculation is a function in that package.
- One sub-module, ble_tx_timer: a loadable down-counter with a zero flag, shared by RAMP_UP, ACTIVE timeout and RAMP_DOWN.

Test Plan:
- PHY_1M, pdu_len=0, sink always ready, tlast on bit 80 → restart at cycle 41 after start; done with status=OK, bit_count=80; rf_tx_en high for the full span plus 16 cycles.
- PHY_2M, pdu_len=255, random mon_tready stalls under 1024 cycles → status=OK, bit_count=2128, no timeout.
- PHY_1M, pdu_len=4, tlast after 100 bits (expected 112) → status=LEN_ERR, done pulses once.
- Stall with no hs for 1024 cycles in ACTIVE → flush plus restart pulse for 1 cycle, status=TIMEOUT, rf_tx_en falls 16 cycles later.
- abort in the 10th cycle of RAMP_UP; separately, abort coincident with the final hs+tlast → both give status=ABORTED; start while busy produces no second restart.
- areset asserted mid-ACTIVE → all outputs 0 on the next edge, no done; a subsequent start runs a normal packet.

Source files
------------

// File: rtl/ble_types_pkg.sv
// Shared BLE TX types: PHY selection, completion status, framing bit lengths
// and the expected on-air bit count of a packet.
package ble_types_pkg;

  typedef enum logic [1:0] {
    PHY_1M    = 2'd0,
    PHY_2M    = 2'd1,
    PHY_CODED = 2'd2
  } ble_phy_t;

  typedef enum logic [1:0] {
    TX_OK      = 2'd0,
    TX_TIMEOUT = 2'd1,
    TX_LEN_ERR = 2'd2,
    TX_ABORTED = 2'd3
  } tx_status_t;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_RAMP_UP   = 3'd1,
    ST_ACTIVE    = 3'd2,
    ST_FLUSH     = 3'd3,
    ST_RAMP_DOWN = 3'd4,
    ST_DONE      = 3'd5
  } seq_state_t;

  localparam int PREAMBLE_1M_BITS = 8;
  localparam int PREAMBLE_2M_BITS = 16;
  localparam int ACCESS_ADDR_BITS = 32;
  localparam int CRC_BITS         = 24;

  localparam int LEN_WIDTH = 12;
  typedef logic [LEN_WIDTH-1:0] len_t;

  // Header (2 bytes) plus payload, all in bits; coded PHY callers skip the check.
  function automatic len_t expected_len(ble_phy_t phy, logic [7:0] pdu_len);
    len_t preamble;
    preamble = (phy == PHY_2M) ? len_t'(PREAMBLE_2M_BITS) : len_t'(PREAMBLE_1M_BITS);
    return preamble + len_t'(ACCESS_ADDR_BITS)
         + ((len_t'(pdu_len) + len_t'(2)) << 3) + len_t'(CRC_BITS);
  endfunction

endpackage

// File: rtl/ble_tx_sequencer_timer.sv
// Loadable down-counter with a zero flag; stops at zero, load beats decrement.
module ble_tx_timer #(
  parameter int Width = 11
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [Width-1:0] load_val,
  input  logic             dec,
  output logic             zero
);

  logic [Width-1:0] cnt_q;
  logic [Width-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/ble_tx_sequencer.sv
// BLE TX chain controller: RF ramp, datapath restart/flush, bit counting on the
// final-stage handshake, timeout/length/abort detection and completion status.
module ble_tx_sequencer
  import ble_types_pkg::*;
#(
  parameter int RampUpCycles   = 40,
  parameter int RampDownCycles = 16,
  parameter int TimeoutCycles  = 1024,
  parameter int CntWidth       = 12
) (
  input  logic                aclk,
  input  logic                areset,
  input  logic                start,
  input  logic                abort,
  input  logic [1:0]          phy,
  input  logic [7:0]          pdu_len,
  output logic                restart,
  output logic                flush,
  output logic                rf_tx_en,
  input  logic                mon_tvalid,
  input  logic                mon_tready,
  input  logic                mon_tlast,
  output logic                busy,
  output logic                done,
  output logic [1:0]          status,
  output logic [CntWidth-1:0] bit_count
);

  localparam int TmrWidth = $clog2(TimeoutCycles + RampUpCycles + RampDownCycles + 1);

  seq_state_t          state_q, state_d;
  tx_status_t          status_q, status_d;
  logic                rf_tx_en_q, rf_tx_en_d;
  logic                restart_q, restart_d;
  logic                coded_q, coded_d;
  logic [CntWidth-1:0] bit_count_q, bit_count_d;
  logic [CntWidth-1:0] exp_len_q, exp_len_d;

  logic                tmr_load;
  logic [TmrWidth-1:0] tmr_val;
  logic                tmr_dec;
  logic                tmr_zero;

  logic                hs;
  logic                bit_sat;
  logic [CntWidth-1:0] cnt_inc;

  assign hs      = mon_tvalid & mon_tready;
  assign bit_sat = &bit_count_q;
  assign cnt_inc = bit_sat ? bit_count_q : bit_count_q + 1'b1;

  ble_tx_timer #(.Width(TmrWidth)) u_timer (
    .clk      (aclk),
    .rst      (areset),
    .load     (tmr_load),
    .load_val (tmr_val),
    .dec      (tmr_dec),
    .zero     (tmr_zero)
  );

  always_comb begin
    state_d     = state_q;
    status_d    = status_q;
    rf_tx_en_d  = rf_tx_en_q;
    restart_d   = 1'b0;
    coded_d     = coded_q;
    bit_count_d = bit_count_q;
    exp_len_d   = exp_len_q;
    tmr_load    = 1'b0;
    tmr_val     = '0;
    tmr_dec     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          exp_len_d   = CntWidth'(expected_len(ble_phy_t'(phy), pdu_len));
          coded_d     = (ble_phy_t'(phy) == PHY_CODED);
          bit_count_d = '0;
          status_d    = TX_OK;
          rf_tx_en_d  = 1'b1;
          tmr_load    = 1'b1;
          tmr_val     = TmrWidth'(RampUpCycles - 1);
          state_d     = ST_RAMP_UP;
        end
      end

      ST_RAMP_UP: begin
        if (abort) begin
          status_d  = TX_ABORTED;
          restart_d = 1'b1;
          state_d   = ST_FLUSH;
        end else if (tmr_zero) begin
          restart_d = 1'b1;
          tmr_load  = 1'b1;
          tmr_val   = TmrWidth'(TimeoutCycles - 1);
          state_d   = ST_ACTIVE;
        end else begin
          tmr_dec = 1'b1;
        end
      end

      ST_ACTIVE: begin
        tmr_dec = !hs;
        if (hs) begin
          bit_count_d = cnt_inc;
          tmr_load    = 1'b1;
          tmr_val     = TmrWidth'(TimeoutCycles - 1);
        end
        // Abort outranks a coincident final beat; the beat is still counted.
        if (abort) begin
          status_d  = TX_ABORTED;
          restart_d = 1'b1;
          state_d   = ST_FLUSH;
        end else if (hs && mon_tlast) begin
          status_d = (!coded_q && (bit_sat || (cnt_inc != exp_len_q))) ? TX_LEN_ERR : TX_OK;
          tmr_load = 1'b1;
          tmr_val  = TmrWidth'(RampDownCycles - 1);
          state_d  = ST_RAMP_DOWN;
        end else if (!hs && tmr_zero) begin
          status_d  = TX_TIMEOUT;
          restart_d = 1'b1;
          state_d   = ST_FLUSH;
        end
      end

      ST_FLUSH: begin
        tmr_load = 1'b1;
        tmr_val  = TmrWidth'(RampDownCycles - 1);
        state_d  = ST_RAMP_DOWN;
      end

      ST_RAMP_DOWN: begin
        if (tmr_zero) begin
          rf_tx_en_d = 1'b0;
          state_d    = ST_DONE;
        end else begin
          tmr_dec = 1'b1;
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        rf_tx_en_d = 1'b0;
        state_d    = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q     <= ST_IDLE;
      status_q    <= TX_OK;
      rf_tx_en_q  <= 1'b0;
      restart_q   <= 1'b0;
      coded_q     <= 1'b0;
      bit_count_q <= '0;
      exp_len_q   <= '0;
    end else begin
      state_q     <= state_d;
      status_q    <= status_d;
      rf_tx_en_q  <= rf_tx_en_d;
      restart_q   <= restart_d;
      coded_q     <= coded_d;
      bit_count_q <= bit_count_d;
      exp_len_q   <= exp_len_d;
    end
  end

  assign restart   = restart_q;
  assign flush     = (state_q == ST_FLUSH);
  assign rf_tx_en  = rf_tx_en_q;
  assign busy      = (state_q != ST_IDLE);
  assign done      = (state_q == ST_DONE);
  assign status    = status_q;
  assign bit_count = bit_count_q;

endmodule

// File: tb/tb_ble_tx_sequencer.sv
// Scoreboarded bench for ble_tx_sequencer: directed packets push expected
// completion records; a monitor pops and compares on every done pulse.
module tb_ble_tx_sequencer;
  import ble_types_pkg::*;

  localparam int CW = 12;

  logic          aclk = 1'b0;
  logic          areset;
  logic          start;
  logic          abort;
  logic [1:0]    phy;
  logic [7:0]    pdu_len;
  logic          restart;
  logic          flush;
  logic          rf_tx_en;
  logic          mon_tvalid;
  logic          mon_tready;
  logic          mon_tlast;
  logic          busy;
  logic          done;
  logic [1:0]    status;
  logic [CW-1:0] bit_count;

  ble_tx_sequencer dut (
    .aclk       (aclk),
    .areset     (areset),
    .start      (start),
    .abort      (abort),
    .phy        (phy),
    .pdu_len    (pdu_len),
    .restart    (restart),
    .flush      (flush),
    .rf_tx_en   (rf_tx_en),
    .mon_tvalid (mon_tvalid),
    .mon_tready (mon_tready),
    .mon_tlast  (mon_tlast),
    .busy       (busy),
    .done       (done),
    .status     (status),
    .bit_count  (bit_count)
  );

  always #5 aclk = ~aclk;

  int cyc = 0;
  always @(posedge aclk) cyc <= cyc + 1;

  typedef struct {
    logic [1:0]    st;
    logic [CW-1:0] cnt;
  } exp_t;
  exp_t exp_q[$];

  int checks = 0;
  int errors = 0;

  int restart_cnt = 0, flush_cnt = 0, done_cnt = 0;
  int restart_cyc = 0, flush_cyc = 0, done_cyc = 0, rf_fall_cyc = 0;
  int start_cyc = 0, last_hs_cyc = 0;
  logic rf_prev = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic push_exp(input logic [1:0] st, input int cnt);
    exp_t e;
    e.st  = st;
    e.cnt = CW'(cnt);
    exp_q.push_back(e);
  endtask

  // Monitor: samples on the falling edge, well away from register updates.
  initial begin
    exp_t e;
    forever begin
      @(negedge aclk);
      if (restart) begin
        restart_cnt++;
        restart_cyc = cyc;
      end
      if (flush) begin
        flush_cnt++;
        flush_cyc = cyc;
      end
      if (rf_prev && !rf_tx_en) rf_fall_cyc = cyc;
      rf_prev = rf_tx_en;
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
        check("exp_available", int'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("status", int'(status), int'(e.st));
          check("bit_count", int'(bit_count), int'(e.cnt));
        end
      end
    end
  end

  task automatic do_start(input logic [1:0] p, input logic [7:0] l);
    @(negedge aclk);
    start     = 1'b1;
    phy       = p;
    pdu_len   = l;
    start_cyc = cyc;
    @(negedge aclk);
    start = 1'b0;
  endtask

  task automatic wait_restart();
    int r0;
    r0 = restart_cnt;
    for (int k = 0; k < 100 && restart_cnt == r0; k++) @(negedge aclk);
    check("restart_seen", int'(restart_cnt != r0), 1);
  endtask

  task automatic wait_done(input int target, input int budget);
    for (int k = 0; k < budget && done_cnt < target; k++) @(negedge aclk);
    check("done_arrived", done_cnt, target);
    repeat (2) @(negedge aclk);
  endtask

  task automatic send_bits(input int n, input bit stall, input bit tlast_en, input bit abort_last);
    int s;
    for (int i = 0; i < n; i++) begin
      if (stall) begin
        s = $urandom_range(0, 3);
        for (int k = 0; k < s; k++) begin
          @(negedge aclk);
          mon_tvalid = 1'b1;
          mon_tready = 1'b0;
          mon_tlast  = tlast_en && (i == n - 1);
        end
      end
      @(negedge aclk);
      mon_tvalid  = 1'b1;
      mon_tready  = 1'b1;
      mon_tlast   = tlast_en && (i == n - 1);
      abort       = abort_last && (i == n - 1);
      last_hs_cyc = cyc;
    end
    @(negedge aclk);
    mon_tvalid = 1'b0;
    mon_tready = 1'b0;
    mon_tlast  = 1'b0;
    abort      = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int r0, f0, d0;
    areset = 1'b1; start = 1'b0; abort = 1'b0; phy = 2'd0; pdu_len = 8'd0;
    mon_tvalid = 1'b0; mon_tready = 1'b0; mon_tlast = 1'b0;
    repeat (3) @(negedge aclk);
    check("reset_outputs", int'({busy, rf_tx_en, restart, flush, done, status, bit_count}), 0);
    areset = 1'b0;
    @(negedge aclk);

    // 1M, empty PDU: 80 bits, latency checks on restart, done and rf_tx_en.
    do_start(2'd0, 8'd0);
    push_exp(TX_OK, 80);
    wait_restart();
    check("t1_restart_latency", restart_cyc - start_cyc, 41);
    check("t1_rf_on_after_start", int'(rf_tx_en), 1);
    send_bits(80, 1'b0, 1'b1, 1'b0);
    wait_done(1, 100);
    check("t1_done_latency", done_cyc - last_hs_cyc, 17);
    check("t1_rf_fall", rf_fall_cyc - last_hs_cyc, 17);

    // 2M, max PDU with random sink stalls: 2128 bits, no timeout.
    do_start(2'd1, 8'd255);
    push_exp(TX_OK, 2128);
    wait_restart();
    send_bits(2128, 1'b1, 1'b1, 1'b0);
    wait_done(2, 200);

    // 1M, pdu_len=4 expects 112 bits; tlast at 100 is a length error.
    do_start(2'd0, 8'd4);
    push_exp(TX_LEN_ERR, 100);
    wait_restart();
    send_bits(100, 1'b0, 1'b1, 1'b0);
    wait_done(3, 100);
    repeat (5) @(negedge aclk);
    check("t3_single_done", done_cnt, 3);

    // Stall after 5 bits: timeout, one flush with its restart, then ramp down.
    r0 = restart_cnt;
    f0 = flush_cnt;
    do_start(2'd0, 8'd0);
    push_exp(TX_TIMEOUT, 5);
    wait_restart();
    send_bits(5, 1'b0, 1'b0, 1'b0);
    wait_done(4, 1200);
    check("t4_flush_count", flush_cnt - f0, 1);
    check("t4_restart_count", restart_cnt - r0, 2);
    check("t4_timeout_time", flush_cyc - last_hs_cyc, 1025);
    check("t4_rf_fall", rf_fall_cyc - flush_cyc, 17);

    // Abort in the 10th RAMP_UP cycle, then a start while busy is ignored.
    r0 = restart_cnt;
    do_start(2'd0, 8'd0);
    push_exp(TX_ABORTED, 0);
    repeat (9) @(negedge aclk);
    abort = 1'b1;
    @(negedge aclk);
    abort = 1'b0;
    repeat (4) @(negedge aclk);
    start = 1'b1;
    @(negedge aclk);
    start = 1'b0;
    wait_done(5, 100);
    repeat (60) @(negedge aclk);
    check("t5_restart_count", restart_cnt - r0, 1);
    check("t5_idle_after", int'(busy), 0);
    check("t5_done_count", done_cnt, 5);

    // Abort coincident with the final beat: abort wins, beat still counted.
    do_start(2'd0, 8'd0);
    push_exp(TX_ABORTED, 80);
    wait_restart();
    send_bits(80, 1'b0, 1'b1, 1'b1);
    wait_done(6, 100);

    // Reset mid-ACTIVE: everything clears, no done pulse.
    do_start(2'd0, 8'd0);
    wait_restart();
    send_bits(10, 1'b0, 1'b0, 1'b0);
    d0 = done_cnt;
    areset = 1'b1;
    @(negedge aclk);
    check("t7_reset_outputs", int'({busy, rf_tx_en, restart, flush, done, status, bit_count}), 0);
    areset = 1'b0;
    repeat (60) @(negedge aclk);
    check("t7_no_done", done_cnt, d0);

    // Coded PHY after reset: no length check, normal completion.
    do_start(2'd2, 8'd3);
    push_exp(TX_OK, 50);
    wait_restart();
    send_bits(50, 1'b0, 1'b1, 1'b0);
    wait_done(7, 100);

    check("queue_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
